bft_stream_packetizer: RTL and testbench

Transmit-side leaf block. It accepts 32-bit user words over the HLS ap_vld/ap_ack handshake and buffers them in a small FIFO. Each word is wrapped into a 49-bit BFT packet addressed to a configured destination leaf and port, and injected toward the BFT under credit-based flow control. Credits are replenished by freespace-update packets returned by the destination leaf interface.

---
 rtl/bft_stream_packetizer.sv | 164 ++++++++++++++++
 tb/tb_bft_stream_packetizer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bft_stream_packetizer.sv
// bft_stream_packetizer: wraps 32-bit user words into BFT packets and injects
// them toward the tree under credit-based flow control. A 4-entry FIFO absorbs
// user words while the output register is stalled or out of credits. Credits
// are returned by port-0 control packets arriving from the BFT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | output register holds no packet (dout[48] = 0)
// S_FULL  | output register holds a packet waiting for bft_accept
module bft_stream_packetizer #(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_LEAF_BITS      = 5,
    parameter int NUM_PORT_BITS      = 4,
    parameter int NUM_ADDR_BITS      = 7,
    parameter int NUM_BRAM_ADDR_BITS = 7,
    parameter int FIFO_DEPTH_BITS    = 2
) (
    input  logic                      clk_bft,
    input  logic                      reset_n,
    input  logic [NUM_LEAF_BITS-1:0]  dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]  dest_port,
    input  logic [PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic                      vld_user2interface,
    output logic                      ack_interface2user,
    output logic [PACKET_BITS-1:0]    dout_leaf_interface2bft,
    input  logic                      bft_accept,
    input  logic [PACKET_BITS-1:0]    din_leaf_bft2interface,
    output logic [NUM_BRAM_ADDR_BITS:0] credits
);

    localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int FIFO_DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int PORT_LSB    = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int PORT_MSB    = PORT_LSB + NUM_PORT_BITS - 1;

    localparam logic [CREDIT_BITS:0]   MAX_CREDITS_W = (CREDIT_BITS + 1)'(1 << NUM_BRAM_ADDR_BITS);
    localparam logic [CREDIT_BITS-1:0] MAX_CREDITS   = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [PAYLOAD_BITS-1:0]    fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   fifo_count;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_wr;
    logic                       fifo_rd;

    logic                       push;
    logic                       head_avail;
    logic [PAYLOAD_BITS-1:0]    head_word;
    logic                       load;

    logic [0:0]                 state;
    logic [0:0]                 state_next;
    logic [NUM_ADDR_BITS-1:0]   addr_cnt;

    logic [CREDIT_BITS-1:0]     credit_cnt;
    logic                       ret_valid;
    logic [CREDIT_BITS-1:0]     ret_amt;
    logic [CREDIT_BITS:0]       credit_sum;
    logic [CREDIT_BITS-1:0]     credit_next;
    logic                       unused_din_bits;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH));

    // ack only depends on registered FIFO state, so a pop in a full cycle
    // does not reopen the input until the following cycle.
    assign ack_interface2user = reset_n && !fifo_full;
    assign push               = vld_user2interface && ack_interface2user;

    // First-word fall-through: a word arriving into an empty FIFO can be
    // loaded into the output register on the same edge it is accepted.
    assign head_avail = !fifo_empty || push;
    assign head_word  = fifo_empty ? din_leaf_user2interface : fifo_mem[rd_ptr];
    assign load       = head_avail && (credit_cnt != '0) &&
                        ((state == S_EMPTY) || bft_accept);

    assign fifo_wr = push && !(fifo_empty && load);
    assign fifo_rd = load && !fifo_empty;

    // Port 0 is reserved for control; only valid port-0 packets return credits.
    assign ret_valid = din_leaf_bft2interface[PACKET_BITS-1] &&
                       (din_leaf_bft2interface[PORT_MSB:PORT_LSB] == '0);
    assign ret_amt   = ret_valid ? din_leaf_bft2interface[CREDIT_BITS-1:0] : '0;

    assign credit_sum  = (CREDIT_BITS + 1)'(credit_cnt) - (CREDIT_BITS + 1)'(load)
                       + (CREDIT_BITS + 1)'(ret_amt);
    assign credit_next = (credit_sum > MAX_CREDITS_W) ? MAX_CREDITS
                                                      : credit_sum[CREDIT_BITS-1:0];
    assign credits     = credit_cnt;

    assign unused_din_bits = ^{din_leaf_bft2interface[PACKET_BITS-2:PORT_MSB+1],
                               din_leaf_bft2interface[PORT_LSB-1:CREDIT_BITS]};

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk_bft) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= din_leaf_user2interface;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_bft or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + (FIFO_DEPTH_BITS + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_DEPTH_BITS + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output register occupancy.
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (load) state_next = S_FULL;
            S_FULL:  if (bft_accept && !load) state_next = S_EMPTY;
            default: state_next = S_EMPTY;
        endcase
    end

    // Output packet register, control state and sequence address.
    always_ff @(posedge clk_bft or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= S_EMPTY;
            dout_leaf_interface2bft <= '0;
            addr_cnt                <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                dout_leaf_interface2bft <= {1'b1, dest_leaf, dest_port, addr_cnt, head_word};
                addr_cnt                <= addr_cnt + NUM_ADDR_BITS'(1);
            end else if (bft_accept) begin
                dout_leaf_interface2bft <= '0;
            end
        end
    end

    // Credit counter: consumption and returns combine in one saturating update.
    always_ff @(posedge clk_bft or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt <= MAX_CREDITS;
        end else begin
            credit_cnt <= credit_next;
        end
    end

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Bench for bft_stream_packetizer: scoreboard of expected packets filled on
// each observed user handshake and drained on each packet consumed by the BFT,
// plus direct checks of credits, handshake and register behaviour.
module tb_bft_stream_packetizer;

    logic        clk_bft = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  dest_leaf = '0;
    logic [3:0]  dest_port = '0;
    logic [31:0] din_user = '0;
    logic        vld = 1'b0;
    logic        ack;
    logic [48:0] dout;
    logic        bft_accept = 1'b0;
    logic [48:0] din_bft = '0;
    logic [7:0]  credits;

    logic [48:0] sb[$];
    logic [6:0]  exp_addr = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_rx = 0;

    bft_stream_packetizer dut (
        .clk_bft                 (clk_bft),
        .reset_n                 (reset_n),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .din_leaf_user2interface (din_user),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .dout_leaf_interface2bft (dout),
        .bft_accept              (bft_accept),
        .din_leaf_bft2interface  (din_bft),
        .credits                 (credits)
    );

    always #5 clk_bft = ~clk_bft;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Scoreboard: sample mid-cycle, ahead of the edge where transfers happen.
    always @(negedge clk_bft) begin
        if (reset_n) begin
            if (dout[48] && bft_accept) begin
                n_rx++;
                if (sb.size() == 0) chk("sb_unexpected", 64'(dout), 64'd0);
                else chk("sb_pkt", 64'(dout), 64'(sb.pop_front()));
            end
            if (vld && ack) begin
                sb.push_back({1'b1, dest_leaf, dest_port, exp_addr, din_user});
                exp_addr++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_bft);
        #1;
    endtask

    // Called and returns at posedge+1; offers one word for one cycle.
    task automatic drive_word(input logic [31:0] w, output bit taken);
        vld = 1'b1;
        din_user = w;
        @(negedge clk_bft);
        taken = ack;
        @(posedge clk_bft);
        #1;
        vld = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        vld = 1'b0;
        din_bft = '0;
        sb.delete();
        exp_addr = '0;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit taken;
        int ntaken;
        int tries;
        int rx0;

        // Reset state
        step(2);
        @(negedge clk_bft);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_credits", 64'(credits), 64'd128);
        @(posedge clk_bft); #1;
        reset_n = 1'b1;
        @(negedge clk_bft);
        chk("rel_ack", 64'(ack), 64'd1);
        @(posedge clk_bft); #1;

        // Single word
        dest_leaf = 5'd3; dest_port = 4'd2; bft_accept = 1'b1;
        drive_word(32'hDEADBEEF, taken);
        chk("single_taken", 64'(taken), 64'd1);
        chk("single_dout", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        chk("single_credits", 64'(credits), 64'd127);
        step(1);
        chk("single_drop", 64'(dout[48]), 64'd0);

        // Backpressure
        do_reset();
        dest_leaf = 5'd4; dest_port = 4'd1; bft_accept = 1'b0;
        ntaken = 0;
        for (int i = 0; i < 8; i++) begin
            drive_word(32'hA000_0000 + 32'(ntaken), taken);
            if (taken) ntaken++;
            if (i > 0) chk("bp_hold", 64'(dout), 64'({1'b1, 5'd4, 4'd1, 7'd0, 32'hA000_0000}));
        end
        chk("bp_count", 64'(ntaken), 64'd5);
        chk("bp_ack", 64'(ack), 64'd0);
        rx0 = n_rx;
        bft_accept = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_bft);
            chk("bp_burst_vld", 64'(dout[48]), 64'd1);
        end
        @(negedge clk_bft);
        chk("bp_burst_end", 64'(dout[48]), 64'd0);
        @(posedge clk_bft); #1;
        chk("bp_rx", 64'(n_rx - rx0), 64'd5);

        // Credit exhaustion and address wrap
        do_reset();
        dest_leaf = 5'd9; dest_port = 4'd6; bft_accept = 1'b1;
        rx0 = n_rx; ntaken = 0; tries = 0;
        while (ntaken < 130 && tries < 400) begin
            drive_word(32'h5000_0000 + 32'(ntaken), taken);
            if (taken) ntaken++;
            tries++;
        end
        chk("ex_taken", 64'(ntaken), 64'd130);
        step(3);
        chk("ex_dout_idle", 64'(dout[48]), 64'd0);
        chk("ex_credits0", 64'(credits), 64'd0);
        chk("ex_rx128", 64'(n_rx - rx0), 64'd128);
        din_bft = {1'b1, 5'd0, 4'd0, 7'd0, 32'd64};
        step(1);
        din_bft = '0;
        step(4);
        chk("ex_rx130", 64'(n_rx - rx0), 64'd130);
        chk("ex_credits62", 64'(credits), 64'd62);
        chk("ex_idle2", 64'(dout[48]), 64'd0);

        // Saturation, simultaneous load+return, ignored packets
        do_reset();
        dest_leaf = 5'd1; dest_port = 4'd3; bft_accept = 1'b1;
        din_bft = {1'b1, 5'd0, 4'd0, 7'd0, 32'd5};
        step(1);
        din_bft = '0;
        chk("sat_128", 64'(credits), 64'd128);
        ntaken = 0; tries = 0;
        while (ntaken < 127 && tries < 300) begin
            drive_word(32'hC000_0000 + 32'(ntaken), taken);
            if (taken) ntaken++;
            tries++;
        end
        chk("sim_credits1", 64'(credits), 64'd1);
        din_bft = {1'b1, 5'd0, 4'd0, 7'd0, 32'd3};
        drive_word(32'hCAFE_F00D, taken);
        din_bft = '0;
        chk("sim_taken", 64'(taken), 64'd1);
        chk("sim_credits3", 64'(credits), 64'd3);
        din_bft = {1'b1, 5'd0, 4'd3, 7'd0, 32'd5};
        step(1);
        din_bft = '0;
        chk("port_ignored", 64'(credits), 64'd3);
        din_bft = {1'b0, 5'd0, 4'd0, 7'd0, 32'd5};
        step(1);
        din_bft = '0;
        chk("invalid_ignored", 64'(credits), 64'd3);
        step(2);

        // Reset during a full-FIFO stall
        do_reset();
        dest_leaf = 5'd2; dest_port = 4'd8; bft_accept = 1'b0;
        ntaken = 0;
        for (int i = 0; i < 8; i++) begin
            drive_word(32'hB000_0000 + 32'(ntaken), taken);
            if (taken) ntaken++;
        end
        chk("mid_stall_ack", 64'(ack), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dout", 64'(dout), 64'd0);
        chk("mid_rst_credits", 64'(credits), 64'd128);
        chk("mid_rst_ack", 64'(ack), 64'd0);
        sb.delete();
        exp_addr = '0;
        @(posedge clk_bft); #1;
        reset_n = 1'b1;
        bft_accept = 1'b1;
        dest_leaf = 5'd7; dest_port = 4'd5;
        drive_word(32'h1234_5678, taken);
        chk("post_rst_taken", 64'(taken), 64'd1);
        chk("post_rst_dout", 64'(dout), 64'({1'b1, 5'd7, 4'd5, 7'd0, 32'h1234_5678}));
        step(3);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
